// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_port_arbiter
// Purpose  : Shares one cache port between an instruction-fetch requester and
//            a data requester. Each transaction is IDLE -> ISSUE -> WAIT ->
//            DONE. Every output comes straight from a register.
// Config   : ARB_ROUND_ROBIN_EN defined   -> round-robin arbitration
//            ARB_ROUND_ROBIN_EN undefined -> data-first arbitration, with a
//                                            fetch starvation limit
// Revision : 1.0 - initial release
// ============================================================================
module cache_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port (read-only)
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] i_dout,
  output logic                  i_valid,
  // data port
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_din,
  input  logic                  d_re,
  input  logic                  d_we,
  output logic [DATA_WIDTH-1:0] d_dout,
  output logic                  d_valid,
  // cache side
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic [DATA_WIDTH-1:0] core_din,
  output logic                  core_re,
  output logic                  core_we,
  output logic                  core_complete,
  input  logic [DATA_WIDTH-1:0] core_dout,
  input  logic                  core_data_valid,
  // status
  output logic                  busy
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0] r_state;
  logic       r_sel_data;   // port that owns the current transaction: 1 = data

  logic w_d_req;
  logic w_any_req;
  logic w_grant_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_data;        // port granted last: 1 = data, 0 = fetch
`else
  localparam int                 c_CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);
  logic [c_CNT_W-1:0] r_starve_cnt;  // consecutive data grants while fetch waited
`endif

  // A data write counts as a data request, even when d_re is low.
  assign w_d_req   = d_re | d_we;
  assign w_any_req = i_re | w_d_req;

  // Arbitration: decide whether the data port wins when the FSM is idle.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_data = w_d_req & (~i_re | ~r_last_data);
`else
  assign w_grant_data = w_d_req & (~i_re | (r_starve_cnt < c_STARVE_MAX));
`endif

  // Transaction FSM, cache strobes, and capture of the returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_S_IDLE;
      r_sel_data    <= 1'b0;
      busy          <= 1'b0;
      core_addr     <= '0;
      core_din      <= '0;
      core_re       <= 1'b0;
      core_we       <= 1'b0;
      core_complete <= 1'b0;
      i_dout        <= '0;
      i_valid       <= 1'b0;
      d_dout        <= '0;
      d_valid       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_data   <= 1'b0;
`else
      r_starve_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_any_req) begin
            r_state    <= c_S_ISSUE;
            busy       <= 1'b1;
            r_sel_data <= w_grant_data;
            if (w_grant_data) begin
              // A write takes precedence when d_re and d_we are both set.
              core_addr <= d_addr;
              core_din  <= d_din;
              core_we   <= d_we;
              core_re   <= ~d_we;
            end else begin
              core_addr <= i_addr;
              core_we   <= 1'b0;
              core_re   <= 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            r_last_data <= w_grant_data;
`else
            if (w_grant_data && i_re) begin
              if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end else begin
              r_starve_cnt <= '0;
            end
`endif
          end
        end

        c_S_ISSUE: begin
          r_state <= c_S_WAIT;
        end

        c_S_WAIT: begin
          if (core_data_valid) begin
            r_state       <= c_S_DONE;
            core_re       <= 1'b0;
            core_we       <= 1'b0;
            core_complete <= 1'b1;
            if (r_sel_data) begin
              d_dout  <= core_dout;
              d_valid <= 1'b1;
            end else begin
              i_dout  <= core_dout;
              i_valid <= 1'b1;
            end
          end
        end

        default: begin
          // DONE: the completion pulses last one cycle, then the FSM returns to idle.
          r_state       <= c_S_IDLE;
          busy          <= 1'b0;
          core_complete <= 1'b0;
          i_valid       <= 1'b0;
          d_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
